display_scanner: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver that generalises the fixed 4-digit scan clock into a complete scanner. It divides `clk` into digit slots, rotates through `NUM_DIGITS` common-anode digits, decodes each hex nibble to segments, inserts an anti-ghosting blank interval per slot, and optionally suppresses leading zeros. It sits between any value-producing datapath (adder, counter) and the board's anode/segment pins.

---
 rtl/display_scanner_if.sv | 24 ++
 rtl/display_scanner.sv | 133 +++++++++++++
 tb/tb_display_scanner.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// Bundle between a value-producing datapath and the multiplexed 7-segment scanner.
// The master side supplies the value to show; the slave side drives the board pins.
interface display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic                    frame_tick;

  modport master (
    output en, value, dp, blank_lz,
    input  an, seg, dp_n, frame_tick
  );

  modport slave (
    input  en, value, dp, blank_lz,
    output an, seg, dp_n, frame_tick
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode hex display scanner with per-slot anti-ghost blanking,
// frame-synchronous input snapshot and optional leading-zero suppression.
module display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 131072,
  parameter int BLANK_CYCLES = 256
) (
  input logic              clk,
  input logic              rst,
  display_scanner_if.slave bus
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] value_shadow_reg;
  logic [NUM_DIGITS-1:0]   dp_shadow_reg;
  logic                    blz_shadow_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [6:0]              seg_reg;
  logic                    dp_n_reg;
  logic                    tick_reg;

  logic                  slot_end;
  logic                  frame_end;
  logic                  show;
  logic [NUM_DIGITS:0]   zero_above;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic                  lz_sel;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_n_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST) && bus.en;
  assign show      = (int'(cnt_reg) >= BLANK_CYCLES);

  // zero_above[i] is set when nibble i and every more-significant nibble are zero.
  assign zero_above[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign zero_above[gi] = (value_shadow_reg[4*gi +: 4] == 4'h0) && zero_above[gi+1];
      assign an_next[gi]    = !(bus.en && show && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    nibble = 4'h0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        nibble = value_shadow_reg[4*i +: 4];
        dp_sel = dp_shadow_reg[i];
        lz_sel = (i != 0) && zero_above[i];
      end
    end
  end

  // A suppressed digit keeps its anode and decimal point; only the segments go dark.
  always_comb begin
    seg_next  = 7'h7F;
    dp_n_next = 1'b1;
    if (bus.en && show) begin
      seg_next  = (blz_shadow_reg && lz_sel) ? 7'h7F : hex_to_seg(nibble);
      dp_n_next = ~dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg          <= '0;
      idx_reg          <= '0;
      value_shadow_reg <= '0;
      dp_shadow_reg    <= '0;
      blz_shadow_reg   <= 1'b0;
      an_reg           <= '1;
      seg_reg          <= 7'h7F;
      dp_n_reg         <= 1'b1;
      tick_reg         <= 1'b0;
    end else begin
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      dp_n_reg <= dp_n_next;
      tick_reg <= frame_end;
      if (bus.en) begin
        if (slot_end) begin
          cnt_reg <= '0;
          idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (frame_end) begin
        value_shadow_reg <= bus.value;
        dp_shadow_reg    <= bus.dp;
        blz_shadow_reg   <= bus.blank_lz;
      end
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.dp_n       = dp_n_reg;
  assign bus.frame_tick = tick_reg;
endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: a 4-digit instance and a 1-digit no-blank instance run
// side by side against a position-based reference model, compared every cycle.
module tb_display_scanner;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  display_scanner_if #(.NUM_DIGITS(4)) bus_a ();
  display_scanner_if #(.NUM_DIGITS(1)) bus_b ();

  assign bus_a.en = en;
  assign bus_b.en = en;

  display_scanner #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  display_scanner #(.NUM_DIGITS(1), .PRESCALE(8), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int cmp_count  = 0;
  int fail_count = 0;

  // Model state: position in the frame (cycles of enabled scanning) plus the snapshot.
  int          pos_a = 0;
  int          pos_b = 0;
  logic [15:0] shv_a = '0;
  logic [3:0]  shd_a = '0;
  logic        shb_a = 1'b0;
  logic [3:0]  shv_b = '0;
  logic        shd_b = 1'b0;
  logic        shb_b = 1'b0;
  int          ticks_a = 0;
  int          ticks_b = 0;

  function automatic obs_t model_out(input int n, input int p, input int b, input int pos,
                                     input logic [15:0] v, input logic [3:0] d,
                                     input logic blz, input logic e, input logic r);
    obs_t o;
    int   cnt;
    int   idx;
    logic [15:0] upper;
    logic [3:0]  nib;
    o = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, tick: 1'b0};
    if (r || !e) return o;
    cnt    = pos % p;
    idx    = (pos / p) % n;
    o.tick = (cnt == p - 1) && (idx == n - 1);
    if (cnt >= b) begin
      o.an[idx] = 1'b0;
      upper     = v >> (4 * idx);
      nib       = upper[3:0];
      o.seg     = (blz && idx > 0 && upper == 16'h0) ? 7'h7F : hex_tab[nib];
      o.dp_n    = ~d[idx];
    end
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    cmp_count++;
    assert (got === exp) else begin
      fail_count++;
      $error("FAIL %s t=%0t got an=%b seg=%b dp_n=%b tick=%b exp an=%b seg=%b dp_n=%b tick=%b",
             tag, $time, got.an, got.seg, got.dp_n, got.tick, exp.an, exp.seg, exp.dp_n, exp.tick);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    cmp_count++;
    assert (got === exp) else begin
      fail_count++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    obs_t ea, eb, ga, gb;
    ea = model_out(4, 8, 2, pos_a, shv_a, shd_a, shb_a, en, rst);
    eb = model_out(1, 8, 0, pos_b, {12'h0, shv_b}, {3'b0, shd_b}, shb_b, en, rst);
    if (rst) begin
      pos_a = 0; shv_a = '0; shd_a = '0; shb_a = 1'b0;
      pos_b = 0; shv_b = '0; shd_b = 1'b0; shb_b = 1'b0;
    end else if (en) begin
      if (pos_a == 31) begin
        shv_a = bus_a.value; shd_a = bus_a.dp; shb_a = bus_a.blank_lz;
      end
      if (pos_b == 7) begin
        shv_b = bus_b.value; shd_b = bus_b.dp[0]; shb_b = bus_b.blank_lz;
      end
      pos_a = (pos_a + 1) % 32;
      pos_b = (pos_b + 1) % 8;
    end
    @(posedge clk);
    #1;
    ga = '{an: bus_a.an, seg: bus_a.seg, dp_n: bus_a.dp_n, tick: bus_a.frame_tick};
    gb = '{an: {3'b111, bus_b.an}, seg: bus_b.seg, dp_n: bus_b.dp_n, tick: bus_b.frame_tick};
    check("scan4", ga, ea);
    check("scan1", gb, eb);
    ticks_a += int'(bus_a.frame_tick);
    ticks_b += int'(bus_b.frame_tick);
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic blz);
    bus_a.value    = v;
    bus_a.dp       = d;
    bus_a.blank_lz = blz;
    bus_b.value    = v[3:0];
    bus_b.dp       = d[0:0];
    bus_b.blank_lz = blz;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic run_to(input int target, input string tag);
    int k;
    k = 0;
    while ((pos_a != target) && (k < 100)) begin
      step();
      k++;
    end
    check_int(tag, pos_a, target);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    drive(16'h0000, 4'h0, 1'b0);
    run(2);

    // Scan order and frame period from a clean reset.
    rst = 1'b0;
    en  = 1'b1;
    drive(16'h1234, 4'h0, 1'b0);
    ticks_a = 0;
    ticks_b = 0;
    run(64);
    check_int("ticks4_in_64", ticks_a, 2);
    check_int("ticks1_in_64", ticks_b, 8);

    // Leading-zero suppression.
    drive(16'h0050, 4'($urandom), 1'b1);
    run(96);
    drive(16'h0000, 4'($urandom), 1'b1);
    run(64);

    // Snapshot: change the value mid-frame.
    drive(16'hAAAA, 4'h0, 1'b0);
    run_to(12, "align_snapshot");
    run(32);
    drive(16'hFFFF, 4'h0, 1'b0);
    run(64);

    // Freeze during SHOW of digit 2.
    run_to(20, "align_freeze");
    en = 1'b0;
    ticks_a = 0;
    run(20);
    check_int("no_tick_frozen", ticks_a, 0);
    en = 1'b1;
    run(40);

    // Reset while the frame-end condition is true.
    drive(16'h9C3E, 4'h5, 1'b0);
    run_to(31, "align_reset");
    rst = 1'b1;
    drive(16'h7B0D, 4'hA, 1'b1);
    run(1);
    rst = 1'b0;
    run(48);

    // Randomized inputs and enable.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0)
        drive(16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF),
              4'($urandom), 1'($urandom));
      en = ($urandom_range(0, 9) != 0);
      step();
    end
    en = 1'b1;
    run(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule
